// File: rtl/laser_drop_transmitter_pkg.sv
// laser_drop_pkg: shared FSM state type, frame-length constants and default bit period.
// Build option: LASER_TX_PARITY_EN adds the PARITY state and an 11-bit frame.
package laser_drop_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam int FRAME_BITS_NOPAR = 10;
    localparam int FRAME_BITS_PAR = 11;
`ifdef LASER_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PAR;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    localparam int FRAME_BITS = FRAME_BITS_NOPAR;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif
endpackage

// File: rtl/laser_drop_transmitter_if.sv
// laser_drop_if: upstream byte-queue handshake.
// q_data/q_empty come from the queue (master); q_read is the pop strobe from the transmitter (slave).
interface laser_drop_if;
    logic [7:0] q_data;
    logic       q_empty;
    logic       q_read;
    modport master (output q_data, output q_empty, input q_read);
    modport slave (input q_data, input q_empty, output q_read);
endinterface

// File: rtl/laser_drop_transmitter_bit_timer.sv
// laser_tx_bit_timer: bit-period down-counter.
// Ports: clock, reset (async), clear (sync), i_load (restart a period), i_tick_en (count),
// o_bit_end (one-cycle strobe in the last cycle of each bit period).
module laser_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic i_load,
    input  logic i_tick_en,
    output logic o_bit_end
);
    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);
    logic [7:0] r_cnt;
    assign o_bit_end = i_tick_en && (r_cnt == 8'd0);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_cnt <= 8'd0;
        else if (clear)
            r_cnt <= 8'd0;
        else if (i_load || o_bit_end)
            r_cnt <= RELOAD;
        else if (i_tick_en)
            r_cnt <= r_cnt - 8'd1;
    end
endmodule

// File: rtl/laser_drop_transmitter.sv
// laser_drop_transmitter: serialises bytes from an upstream queue onto a laser line.
// Ports: clock, reset (async, active-high), clear (sync abort), enable (allow new frames),
// q (laser_drop_if.slave: q_data, q_empty in; q_read out), laser_out (registered serial line),
// busy, byte_done (last cycle of stop bit), byte_count (frames since reset/clear).
// Build option: LASER_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module laser_drop_transmitter
    import laser_drop_pkg::*;
#(
    parameter int   CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    laser_drop_if.slave       q,
    output logic              laser_out,
    output logic              busy,
    output logic              byte_done,
    output logic [15:0]       byte_count
);
    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [2:0]  r_bit_idx;
    logic [15:0] r_byte_count;
    logic        r_laser;
    logic        w_laser_next;
    logic        w_bit_end;
    logic        w_q_read;
    logic        w_byte_done;
    logic        w_can_start;
`ifdef LASER_TX_PARITY_EN
    logic        r_parity;
`endif

    laser_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .i_load    (w_q_read),
        .i_tick_en (busy),
        .o_bit_end (w_bit_end)
    );

    assign w_can_start = enable && !q.q_empty;
    assign busy        = (r_state != IDLE);
    assign q.q_read    = w_q_read;
    assign byte_done   = w_byte_done;
    assign laser_out   = r_laser;
    assign byte_count  = r_byte_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // The last STOP cycle can pop the next byte so back-to-back frames leave no gap.
    always_comb begin
        w_state_next = r_state;
        w_q_read = 1'b0;
        w_byte_done = 1'b0;
        if (clear)
            w_state_next = IDLE;
        else
            case (r_state)
                IDLE: if (w_can_start) begin
                    w_q_read = 1'b1;
                    w_state_next = START;
                end
                START: if (w_bit_end) w_state_next = DATA;
                DATA: if (w_bit_end && r_bit_idx == 3'd7)
`ifdef LASER_TX_PARITY_EN
                    w_state_next = PARITY;
                PARITY: if (w_bit_end) w_state_next = STOP;
`else
                    w_state_next = STOP;
`endif
                STOP: if (w_bit_end) begin
                    w_byte_done = 1'b1;
                    w_q_read = w_can_start;
                    w_state_next = w_can_start ? START : IDLE;
                end
                default: w_state_next = IDLE;
            endcase
    end

    // laser_out is registered from the next state so it lines up with the state it belongs to.
    always_comb begin
        w_shift_next = w_q_read ? q.q_data : (r_state == DATA && w_bit_end) ? {1'b0, r_shift[7:1]} : r_shift;
        w_laser_next = (w_state_next == START) ? ~IDLE_LEVEL :
                       (w_state_next == DATA) ? w_shift_next[0] :
`ifdef LASER_TX_PARITY_EN
                       (w_state_next == PARITY) ? r_parity :
`endif
                       IDLE_LEVEL;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || clear) begin
            r_shift <= 8'd0;
            r_bit_idx <= 3'd0;
            r_laser <= IDLE_LEVEL;
            r_byte_count <= 16'd0;
`ifdef LASER_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_shift <= w_shift_next;
            r_laser <= w_laser_next;
            if (r_state == DATA && w_bit_end)
                r_bit_idx <= r_bit_idx + 3'd1;
            if (w_byte_done)
                r_byte_count <= r_byte_count + 16'd1;
`ifdef LASER_TX_PARITY_EN
            if (w_q_read)
                r_parity <= ^q.q_data;
`endif
        end
    end
endmodule
